// File: rtl/strip_frame_loader_if.sv
// Byte-stream handshake into the strip frame loader: one colour byte per
// transfer, R then G then B for each pixel.
interface strip_frame_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/strip_frame_loader.sv
// Assembles an RGB byte stream into a shadow frame and publishes it to the
// strip bus in a single commit cycle, so the encoder never sees a half-loaded frame.
module strip_frame_loader #(
    parameter int LENGTH      = 10,
    parameter bit AUTO_COMMIT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    strip_frame_loader_if.slave          in_if,
    output logic [LENGTH*24-1:0]         strip_o,
    output logic                         frame_done_o,
    output logic [$clog2(LENGTH+1)-1:0]  pixel_count_o,
    output logic                         err_overflow_o,
    output logic                         err_partial_o
);
    localparam int CW = $clog2(LENGTH+1);

    typedef enum logic {LOAD, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [15:0]           hold_q, hold_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [CW-1:0]         pixel_count_q, pixel_count_d;
    logic [LENGTH*24-1:0]  shadow_q, shadow_d;
    logic [LENGTH*24-1:0]  strip_q, strip_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_overflow_q, err_overflow_d;
    logic                  err_partial_q, err_partial_d;
    logic                  ready;
    logic                  accept;
    logic                  completes;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            hold_q         <= '0;
            byte_idx_q     <= '0;
            pixel_count_q  <= '0;
            shadow_q       <= '0;
            strip_q        <= '0;
            frame_done_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            err_partial_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            byte_idx_q     <= byte_idx_d;
            pixel_count_q  <= pixel_count_d;
            shadow_q       <= shadow_d;
            strip_q        <= strip_d;
            frame_done_q   <= frame_done_d;
            err_overflow_q <= err_overflow_d;
            err_partial_q  <= err_partial_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        byte_idx_d     = byte_idx_q;
        pixel_count_d  = pixel_count_q;
        shadow_d       = shadow_q;
        strip_d        = strip_q;
        frame_done_d   = 1'b0;
        err_overflow_d = 1'b0;
        err_partial_d  = 1'b0;
        ready          = 1'b0;
        accept         = 1'b0;
        completes      = 1'b0;

        case (state_q)
            LOAD: begin
                ready  = rst_n;
                accept = in_if.in_valid && ready;
                if (accept) begin
                    // A full buffer still accepts so the source drains, but discards the byte.
                    if (pixel_count_q == CW'(LENGTH)) begin
                        err_overflow_d = 1'b1;
                    end else begin
                        case (byte_idx_q)
                            2'd0: begin
                                hold_d[15:8] = in_if.in_data;
                                byte_idx_d   = 2'd1;
                            end
                            2'd1: begin
                                hold_d[7:0] = in_if.in_data;
                                byte_idx_d  = 2'd2;
                            end
                            default: begin
                                for (int p = 0; p < LENGTH; p++) begin
                                    if (pixel_count_q == CW'(p)) begin
                                        shadow_d[p*24 +: 24] = {hold_q, in_if.in_data};
                                    end
                                end
                                pixel_count_d = pixel_count_q + CW'(1);
                                byte_idx_d    = 2'd0;
                                completes     = 1'b1;
                            end
                        endcase
                    end
                    if (in_if.in_last && byte_idx_d != 2'd0) begin
                        err_partial_d = 1'b1;
                    end
                    if (in_if.in_last ||
                        (AUTO_COMMIT && completes && pixel_count_q == CW'(LENGTH - 1))) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                strip_d       = shadow_q;
                frame_done_d  = 1'b1;
                pixel_count_d = '0;
                byte_idx_d    = 2'd0;
                state_d       = LOAD;
            end
        endcase
    end

    assign in_if.in_ready = ready;
    assign strip_o        = strip_q;
    assign frame_done_o   = frame_done_q;
    assign pixel_count_o  = pixel_count_q;
    assign err_overflow_o = err_overflow_q;
    assign err_partial_o  = err_partial_q;
endmodule

// File: doc/strip_frame_loader.md
Name: strip_frame_loader

Overview:
- Upstream feeder for the multi-pixel LED encoder. Accepts a byte stream (R, G, B per pixel) over a valid/ready handshake and assembles it into a shadow frame buffer.
- On frame commit, copies the shadow buffer to the registered `strip` bus. The encoder reads that bus continuously.
- Double-buffered: the encoder never sees a half-loaded frame.

Parameters:
- LENGTH, 10, number of pixels on the strip.
- AUTO_COMMIT, 1, 1 = commit automatically when pixel LENGTH-1 completes; 0 = commit only on in_last.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  synchronous active-low reset.
- in_data  input  8  colour byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; a byte transfers on a clk edge with in_valid && in_ready.
- in_last  input  1  accompanies the final byte of a frame.
- strip  output  LENGTH*24  committed frame; pixel p at strip[24p+23:24p] = {R,G,B}, R in bits 23:16.
- frame_done  output  1  one-cycle pulse, coincident with the first cycle strip holds a new frame.
- pixel_count  output  $clog2(LENGTH+1)  complete pixels written in the current (uncommitted) frame.
- err_overflow  output  1  one-cycle pulse: byte dropped because the buffer is full.
- err_partial  output  1  one-cycle pulse: frame ended mid-pixel.

Behaviour:
- State machine states:
  - LOAD (reset state): in_ready=1.
  - COMMIT: exactly one cycle, in_ready=0.
- Reset (rst_n low at a clk edge):
  - strip=0, shadow=0, hold=0, byte_idx=0, pixel_count=0.
  - frame_done=0, err_*=0, state=LOAD.
  - in_ready=0 while rst_n is low.
  - Reset mid-frame discards everything, including the shadow buffer.
- Byte accept in LOAD:
  - byte_idx 0 → hold[23:16]=in_data (R).
  - byte_idx 1 → hold[15:8]=in_data (G).
  - byte_idx 2 → shadow[pixel_count] <= {hold[23:8], in_data}, pixel_count+1, byte_idx back to 0.
  - byte_idx otherwise increments by 1.
- Full buffer (pixel_count==LENGTH, only reachable with AUTO_COMMIT=0):
  - Accepted bytes are dropped; err_overflow pulses the next cycle; in_ready stays 1 so the source drains.
- Commit triggers, evaluated on the accepting edge, after the byte is processed:
  - (a) in_last=1;
  - (b) AUTO_COMMIT=1 and the byte completes pixel LENGTH-1.
  - Both triggers on the same byte → a single commit.
  - The next state is COMMIT.
- in_last on a byte that leaves byte_idx≠0:
  - The partial pixel is discarded; hold is not written to shadow.
  - err_partial pulses the next cycle, and the commit still occurs.
- COMMIT cycle, on the edge leaving it:
  - strip <= shadow; frame_done=1 for one cycle.
  - pixel_count=0, byte_idx=0, state=LOAD.
- Latency: the last byte is accepted at edge N; strip updates and frame_done rises at edge N+1; in_ready returns at edge N+1.
- Shadow buffer contents persist across frames:
  - A short frame (k<LENGTH pixels, then in_last) updates only pixels 0..k-1.
  - Pixels k..LENGTH-1 keep their prior values.
- in_last on a byte dropped as overflow still commits.
- With AUTO_COMMIT=1, a byte arriving after an auto-commit starts a new frame at pixel 0; in_last is not required.
- in_valid while in_ready=0 is ignored; the source must hold the byte.
- strip changes only on the edge leaving COMMIT or on reset; it never changes mid-load.

Test Plan:
- LENGTH=4, AUTO_COMMIT=1; reset, stream 12 bytes 0x01..0x0C with no in_last → strip={0x0A0B0C,0x070809,0x040506,0x010203} (pixel3..pixel0); frame_done 1 cycle after the 12th byte; pixel_count returns to 0.
- Same, but in_valid toggled randomly and bytes stalled during COMMIT → identical strip; no byte lost or duplicated; in_ready=0 exactly in the COMMIT cycle.
- LENGTH=4, after frame 1 send 6 bytes 0xFF.. with in_last on the 6th → pixels 0–1=0xFFFFFF, pixels 2–3 unchanged; err_partial=0.
- Send 4 bytes, in_last on the 4th → pixel0 written, partial pixel1 discarded; err_partial pulse; commit occurs; pixel1 unchanged.
- AUTO_COMMIT=0, LENGTH=4; send 14 bytes with in_last on the 14th → strip updates once after byte 14; err_overflow pulses for bytes 13 and 14.
- Assert rst_n low after 7 bytes of a frame → strip=0, pixel_count=0, no frame_done; a subsequent full frame loads correctly from pixel 0.
